// File: rtl/scarv_mem_arbiter.sv
// Purpose: shares one native PicoRV32-style memory port between two requesters.
// Latency: grant and m_valid one cycle after a request is seen in IDLE; response
//          is routed back combinationally; one idle (GAP) cycle follows each transfer.
// Backpressure: requesters hold valid until their ready pulse; the granted request
//          is held stable downstream until m_ready, even if the requester drops it.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   r{0,1}_valid/instr/addr/wdata/wstrb   requester inputs (wstrb == 0 is a read)
//   r{0,1}_ready/rdata     completion pulse and read data back to each requester
//   m_valid/instr/addr/wdata/wstrb        registered request to the downstream port
//   m_ready/m_rdata        downstream completion and read data
//   grant                  one-hot owner {port1, port0}, 00 when no transfer is open
module scarv_mem_arbiter #(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        r0_valid,
  input  logic        r0_instr,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_wstrb,
  output logic        r0_ready,
  output logic [31:0] r0_rdata,

  input  logic        r1_valid,
  input  logic        r1_instr,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_wstrb,
  output logic        r1_ready,
  output logic [31:0] r1_rdata,

  output logic        m_valid,
  output logic        m_instr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,

  output logic [1:0]  grant
);

  localparam bit RR = (ROUND_ROBIN != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;     // port that completed the most recent transfer

  logic        m_instr_q, m_instr_d;
  logic [31:0] m_addr_q,  m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;

  logic        any_req;
  logic        pick1;

  assign any_req = r0_valid | r1_valid;
  // Port 1 wins if it is alone, or on contention when round-robin says port 0
  // had the last turn.
  assign pick1   = r1_valid & (~r0_valid | (RR & ~last_q));

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = pick1 ? GNT1 : GNT0;
        end
      end
      GNT0: begin
        if (m_ready) begin
          state_d = GAP;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (m_ready) begin
          state_d = GAP;
          last_d  = 1'b1;
        end
      end
      GAP: begin
        // Forces m_valid low for a cycle so the adapter's handshake state clears.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture: fields are sampled only at grant time, so later changes on
  // the requester side cannot disturb an open downstream transfer.
  always_comb begin
    m_instr_d = m_instr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    if (state_q == IDLE && any_req) begin
      if (pick1) begin
        m_instr_d = r1_instr;
        m_addr_d  = r1_addr;
        m_wdata_d = r1_wdata;
        m_wstrb_d = r1_wstrb;
      end else begin
        m_instr_d = r0_instr;
        m_addr_d  = r0_addr;
        m_wdata_d = r0_wdata;
        m_wstrb_d = r0_wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_instr_q <= 1'b0;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      m_wstrb_q <= 4'h0;
    end else begin
      m_instr_q <= m_instr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

  // Output logic. A ready pulse is qualified by the requester still holding
  // valid: an abandoned transfer completes downstream but is silently dropped.
  always_comb begin
    m_valid  = 1'b0;
    grant    = 2'b00;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    unique case (state_q)
      GNT0: begin
        m_valid  = 1'b1;
        grant    = 2'b01;
        r0_ready = m_ready & r0_valid;
      end
      GNT1: begin
        m_valid  = 1'b1;
        grant    = 2'b10;
        r1_ready = m_ready & r1_valid;
      end
      default: begin
        m_valid  = 1'b0;
        grant    = 2'b00;
      end
    endcase
  end

  assign m_instr  = m_instr_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;

  // Read data is an unqualified pass-through; ready says when it is meaningful.
  assign r0_rdata = m_rdata;
  assign r1_rdata = m_rdata;

endmodule

// File: doc/scarv_mem_arbiter.md
# scarv_mem_arbiter

Two-port arbiter that shares one native PicoRV32-style memory port (the input side of the team's AXI4-lite adapter) between two requesters, typically the core fetch port (port 0) and a data/coprocessor port (port 1). It registers the winning request, holds it stable downstream until the downstream ready pulse, routes the response back, and inserts one idle cycle between transfers. The idle cycle guarantees the downstream `m_valid` drops, so per-transfer handshake state in the AXI adapter clears.

## Interface
Parameters:
- `ROUND_ROBIN`, default 1: 1 = alternate priority on contention; 0 = fixed priority, port 0 always wins.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `r0_valid`, `r1_valid`  in  1  request valid; held until the matching ready
- `r0_instr`, `r1_instr`  in  1  instruction-fetch qualifier
- `r0_addr`, `r1_addr`  in  32  byte address
- `r0_wdata`, `r1_wdata`  in  32  write data
- `r0_wstrb`, `r1_wstrb`  in  4  byte strobes; 0 = read
- `r0_ready`, `r1_ready`  out  1  one-cycle completion pulse
- `r0_rdata`, `r1_rdata`  out  32  read data; valid when the matching ready is high
- `m_valid`  out  1  downstream request valid
- `m_instr`  out  1  registered instr qualifier of the granted request
- `m_addr`  out  32  registered address
- `m_wdata`  out  32  registered write data
- `m_wstrb`  out  4  registered strobes
- `m_ready`  in  1  downstream completion
- `m_rdata`  in  32  downstream read data
- `grant`  out  2  one-hot owner: {port1, port0}; 00 when idle

## Operation
- States: IDLE, GNT0, GNT1, GAP.
- Reset:
  - state = IDLE, `last` = 1 (port 0 wins the first contention).
  - `m_valid`, `m_instr`, `m_addr`, `m_wdata`, `m_wstrb` = 0; `grant` = 00.
  - `r0_ready` = `r1_ready` = 0.
- IDLE:
  - Only `r0_valid` set: go to GNT0, latch port 0 fields into the `m_*` registers.
  - Only `r1_valid` set: go to GNT1, latch port 1 fields.
  - Both set, `ROUND_ROBIN`=1: grant the port other than `last`.
  - Both set, `ROUND_ROBIN`=0: grant port 0.
  - Neither set: stay in IDLE.
- GNTx:
  - `m_valid` = 1 and `grant[x]` = 1.
  - `m_*` fields stay constant, independent of requester input changes.
  - Hold in GNTx until `m_ready`.
- On `m_ready` in GNTx:
  - `rx_ready` = `m_ready` & `rx_valid`, combinational.
  - `rx_rdata` = `m_rdata` for both ports (unqualified pass-through).
  - Next state GAP; `last` ← x.
- GAP: `m_valid` = 0, `grant` = 00; unconditionally go to IDLE. No request is accepted in GAP.
- Abort: if the granted requester drops valid before `m_ready`:
  - The transfer continues to completion, because AXI cannot cancel it.
  - The response is discarded, with no ready pulse to either port.
  - The FSM then proceeds via GAP as normal.
- A ready pulse is never given to the non-granted port.
- `m_ready` is ignored in IDLE and GAP (protocol error, no effect).

## Timing
- Request arriving in IDLE at cycle N: GNTx and `m_valid`=1 at N+1.
- `m_ready` at cycle M: `rx_ready` in the same cycle M; `m_valid`=0 at M+1 (GAP); IDLE at M+2; next grant no earlier than M+3.
- Minimum arbiter overhead per transfer: 3 cycles beyond the downstream latency.
- A requester re-asserting (or keeping) valid at M+1 is treated as a new request, sampled in IDLE at M+2.
- Reset asserted mid-transfer: next cycle is IDLE with all outputs at reset values. The downstream is reset by the same `resetn`.

## Test plan
- Single read, port 0, `r0_addr`=0x0000_1000, `m_ready` 2 cycles after `m_valid` with `m_rdata`=0xDEADBEEF -> `m_addr`=0x1000, `m_wstrb`=0; `r0_ready` for 1 cycle with `r0_rdata`=0xDEADBEEF; `m_valid` low the next cycle.
- Both ports request every cycle, `ROUND_ROBIN`=1, port 0 addr 0x100, port 1 addr 0x200 -> downstream address sequence 0x100, 0x200, 0x100, 0x200; `m_valid` low exactly 2 cycles between transfers.
- Same stimulus with `ROUND_ROBIN`=0 -> only 0x100 transfers; port 1 is starved until `r0_valid` drops.
- Port 1 write, `r1_wstrb`=0xF, `r1_wdata`=0x12345678; `r1_addr` changed to 0xFFFF_FFFF one cycle after the grant -> `m_addr` unchanged and `m_wdata`=0x12345678 throughout; `r1_ready` pulses once.
- Port 0 drops `r0_valid` one cycle after the grant -> `m_valid` held until `m_ready`; no `r0_ready`/`r1_ready` pulse; FSM passes through GAP to IDLE.
- Reset while in GNT1 -> next cycle `grant`=00, `m_valid`=0, `m_addr`=0; first subsequent contention is won by port 0.
